// File: rtl/dsp_cfg_pkg.sv
// Shared definitions for the MF1 DSP configuration path: loader FSM states and the
// default chain geometry, so the DSP tile and the loader agree on chain length.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } cfg_state_t;

  localparam int CFG_BITS_DEFAULT = 24;
  localparam int CFG_WORD_DEFAULT = 8;

  function automatic int cfg_num_words(input int bits, input int width);
    return (bits + width - 1) / width;
  endfunction

endpackage

// File: rtl/dsp_cfg_serializer.sv
// Loadable MSB-first shift register with a per-word bit counter. The caller drives the
// first bit of a word straight from the loaded word, so the counter starts at bits-1.
module dsp_cfg_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int CNT_W      = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic [CNT_W-1:0]      i_bits,
  output logic                  o_msb,
  output logic                  o_last
);

  logic [WORD_WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_word << 1;
      r_cnt  <= i_bits - CNT_W'(1);
    end else if (i_shift) begin
      r_sreg <= r_sreg << 1;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_msb  = r_sreg[WORD_WIDTH-1];
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/dsp_config_loader.sv
// Loader FSM: accepts parallel configuration words and serialises them MSB-first to the
// DSP tile. Defining DSP_CFG_PARITY_EN adds the cfg_parity / parity_err check.
module dsp_config_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CONFIG_BITS = CFG_BITS_DEFAULT,
  parameter int WORD_WIDTH  = CFG_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
`ifdef DSP_CFG_PARITY_EN
  input  logic                  cfg_parity,
  output logic                  parity_err,
`endif
  output logic                  cfg_ready,
  output logic                  configuration_input,
  output logic                  configuration_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_WORDS = cfg_num_words(CONFIG_BITS, WORD_WIDTH);
  localparam int REM_W     = $clog2(CONFIG_BITS + 1);
  localparam int CNT_W     = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BITS = CNT_W'(CONFIG_BITS - (NUM_WORDS - 1) * WORD_WIDTH);

  cfg_state_t       r_state, w_state_nxt;
  logic [REM_W-1:0] r_bits_rem, w_bits_rem_nxt;
  logic [CNT_W-1:0] w_word_bits;
  logic             w_load, w_shift, w_last, w_msb, w_bit_nxt;
  logic             w_en_nxt, w_busy_nxt, w_done_nxt;

  // Only the final word can be short, so a word is either full or the remainder.
  assign w_word_bits = (int'(r_bits_rem) <= WORD_WIDTH) ? LAST_BITS : FULL_BITS;
  assign w_bit_nxt   = w_load ? cfg_word[WORD_WIDTH-1] : w_msb;
  assign cfg_ready   = (r_state == FETCH);

  dsp_cfg_serializer #(
    .WORD_WIDTH(WORD_WIDTH),
    .CNT_W     (CNT_W)
  ) u_serializer (
    .clk    (clk),
    .RSTN   (RSTN),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_word (cfg_word),
    .i_bits (w_word_bits),
    .o_msb  (w_msb),
    .o_last (w_last)
  );

  // Abort wins over everything, including a handshake or the last bit of the load.
  always_comb begin
    w_state_nxt    = r_state;
    w_bits_rem_nxt = r_bits_rem;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_en_nxt       = 1'b0;
    w_busy_nxt     = busy;
    w_done_nxt     = 1'b0;
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt    = FETCH;
            w_bits_rem_nxt = REM_W'(CONFIG_BITS);
            w_busy_nxt     = 1'b1;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            w_state_nxt    = SHIFT;
            w_load         = 1'b1;
            w_en_nxt       = 1'b1;
            w_bits_rem_nxt = r_bits_rem - REM_W'(1);
          end
        end
        SHIFT: begin
          if (w_last) begin
            w_state_nxt = (r_bits_rem == '0) ? DONE : FETCH;
          end else begin
            w_shift        = 1'b1;
            w_en_nxt       = 1'b1;
            w_bits_rem_nxt = r_bits_rem - REM_W'(1);
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state              <= IDLE;
      r_bits_rem           <= '0;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      r_state              <= w_state_nxt;
      r_bits_rem           <= w_bits_rem_nxt;
      configuration_enable <= w_en_nxt;
      busy                 <= w_busy_nxt;
      done                 <= w_done_nxt;
      if (w_load || w_shift) begin
        configuration_input <= w_bit_nxt;
      end
    end
  end

`ifdef DSP_CFG_PARITY_EN
  logic w_start_acc, w_enter_done;
  logic r_xor, r_parity_exp;

  assign w_start_acc  = (r_state == IDLE) && start;
  assign w_enter_done = (r_state == SHIFT) && (w_state_nxt == DONE);

  // parity_err is sticky across aborts and only cleared by the next accepted start.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_xor        <= 1'b0;
      r_parity_exp <= 1'b0;
      parity_err   <= 1'b0;
    end else if (w_start_acc) begin
      r_xor        <= 1'b0;
      r_parity_exp <= cfg_parity;
      parity_err   <= 1'b0;
    end else begin
      if (w_load || w_shift) begin
        r_xor <= r_xor ^ w_bit_nxt;
      end
      if (w_enter_done) begin
        parity_err <= r_xor ^ r_parity_exp;
      end
    end
  end
`endif

endmodule

// File: doc/dsp_config_loader.md
Name: dsp_config_loader

Overview:
- Upstream configuration stage for the proposed MF1 DSP freezer tile.
- Accepts the DSP configuration bitstream as parallel words over a valid/ready handshake.
- Serialises the words MSB-first onto the configuration_input / configuration_enable pair that the DSP tile registers and consumes.
- Reports busy and done status to the system controller.

Parameters:
- CONFIG_BITS, 24: total configuration bits to shift into the DSP chain.
- WORD_WIDTH, 8: width of each parallel configuration word.
- NUM_WORDS (localparam), ceil(CONFIG_BITS/WORD_WIDTH): number of words consumed per load.

Ports:
- clk  input  1  single clock; all flops on posedge.
- RSTN  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  cancels an in-progress load.
- cfg_word  input  WORD_WIDTH  configuration word, MSB shifted first.
- cfg_valid  input  1  cfg_word is valid.
- cfg_ready  output  1  loader can accept a word this cycle.
- configuration_input  output  1  serial configuration bit to the DSP tile.
- configuration_enable  output  1  high on every cycle that carries a valid configuration bit.
- busy  output  1  high from the cycle after start until DONE exits.
- done  output  1  one-cycle pulse when the last bit has been driven.

Behaviour:
- Reset values: state=IDLE, cfg_ready=0, configuration_input=0, configuration_enable=0, busy=0, done=0, bit counter=0, shift register=0.
- All outputs are registered except cfg_ready, which is decoded from state (FETCH).
- IDLE:
  - start=1 -> FETCH; bits_remaining <= CONFIG_BITS; busy <= 1.
  - start while not in IDLE is ignored.
- FETCH:
  - cfg_ready=1, configuration_enable=0.
  - On cfg_valid & cfg_ready: sreg <= cfg_word; word_bits <= min(WORD_WIDTH, bits_remaining); go to SHIFT.
- SHIFT, one bit per cycle:
  - configuration_enable <= 1; configuration_input <= sreg[MSB]; sreg shifts left; word_bits and bits_remaining decrement.
  - word_bits reaches 0 with bits_remaining > 0 -> FETCH.
  - bits_remaining reaches 0 -> DONE.
- DONE: done <= 1 for exactly one cycle, busy <= 0, then IDLE.
- Timing: a word accepted in cycle N drives its k bits with configuration_enable=1 in cycles N+1..N+k. Every word boundary inserts at least one enable-low bubble cycle (FETCH).
- Backpressure: cfg_valid low in FETCH holds the FSM; configuration_enable stays 0; no bit is lost or duplicated.
- Partial last word (CONFIG_BITS not a multiple of WORD_WIDTH): only the upper bits_remaining MSBs are shifted; the low bits are discarded.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, configuration_enable=0, busy=0, no done pulse.
  - abort takes priority over a simultaneous handshake or last bit.
- RSTN low mid-operation: immediate return to reset values; the partial chain contents in the DSP are not defined.
- Counters are sized $clog2(CONFIG_BITS+1) and $clog2(WORD_WIDTH+1). No wrap-around: a load always terminates at zero.

Optional Feature:
- Macro: DSP_CFG_PARITY_EN.
- Defined:
  - Adds input cfg_parity (1 bit, sampled with start in IDLE) and output parity_err (1 bit, registered, reset 0).
  - A running XOR covers every bit driven with configuration_enable=1.
  - On entering DONE, parity_err <= (xor != cfg_parity).
  - parity_err is sticky until the next accepted start, which clears it; abort leaves it unchanged.
- Undefined: ports and the XOR logic are absent, with identical timing otherwise.

Decomposition:
- Shared package dsp_cfg_pkg: state enum (IDLE, FETCH, SHIFT, DONE) and the default CONFIG_BITS / WORD_WIDTH constants, so the DSP tile and the loader agree on chain length.
- One natural sub-module, dsp_cfg_serializer: loadable MSB-first shift register with bit counter. The FSM stays in the top module.

Test Plan:
- Basic load (CONFIG_BITS=24, WORD_WIDTH=8): start, then words 0xA5, 0x3C, 0xF0 with valid always high -> serial stream 10100101 00111100 11110000 over 24 enable-high cycles, one bubble after each of words 1 and 2, done pulses once, busy falls with done.
- Partial word (CONFIG_BITS=20): words 0x12, 0x34, 0xFF -> stream 00010010 00110100 1111, exactly 20 enable cycles, no 0x0F bits emitted.
- Backpressure: cfg_valid low for 5 cycles before word 2 -> cfg_ready held high, configuration_enable low throughout the gap, final 24-bit stream unchanged.
- Abort after 10 bits -> configuration_enable low the next cycle, busy=0, no done; a following full load produces the correct 24-bit stream.
- Reset mid-SHIFT: RSTN low asynchronously -> all outputs 0 in the same cycle; after release, start -> normal load.
- DSP_CFG_PARITY_EN: stream 0xA5, 0x3C, 0xF0 (XOR=0) -> cfg_parity=0 gives parity_err=0; cfg_parity=1 gives parity_err=1, which is cleared by the next start.
